tnoc_packet_packer: RTL

Packet-to-flit serializer for a tnoc network interface. Accepts one packet as a header beat plus zero or more payload beats and emits a flit stream in the tnoc flit format {data, tail, head, flit_type}. Sits upstream of the router input port and feeds it directly. Output is registered, with valid/ready backpressure.

---
 rtl/tnoc_packet_packer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/tnoc_packet_packer.sv
// tnoc_packet_packer
//   Serializes one packet (a header beat plus zero or more payload beats) into
//   a tnoc flit stream {data, tail, head, flit_type}. The header is cut into
//   HEADER_FLITS chunks of FLIT_DATA_WIDTH bits, LSB chunk first, with the last
//   chunk zero-padded. Each payload beat becomes one zero-extended flit. The
//   flit output is registered and uses valid/ready backpressure.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_header_valid/o_header_ready, i_header, i_header_no_payload
//                           header beat handshake; no_payload sampled with it
//   i_payload_valid/o_payload_ready, i_payload, i_payload_last
//                           payload beat handshake; last closes the packet
//   o_flit_valid/i_flit_ready, o_flit
//                           flit stream toward the router input port
//   o_packet_count          (TNOC_PACKET_PACKER_STATS_EN only) wrapping count
//                           of tail flits taken downstream
//
// Build option
//   TNOC_PACKET_PACKER_STATS_EN : adds o_packet_count.

module tnoc_packet_packer #(
    parameter int unsigned HEADER_WIDTH    = 100,
    parameter int unsigned PAYLOAD_WIDTH   = 36,
    parameter int unsigned FLIT_DATA_WIDTH = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_header_valid,
    output logic                       o_header_ready,
    input  logic [HEADER_WIDTH-1:0]    i_header,
    input  logic                       i_header_no_payload,
    input  logic                       i_payload_valid,
    output logic                       o_payload_ready,
    input  logic [PAYLOAD_WIDTH-1:0]   i_payload,
    input  logic                       i_payload_last,
    output logic                       o_flit_valid,
    input  logic                       i_flit_ready,
    output logic [FLIT_DATA_WIDTH+2:0] o_flit
`ifdef TNOC_PACKET_PACKER_STATS_EN
    ,
    output logic [15:0]                o_packet_count
`endif
);

    localparam int unsigned HEADER_FLITS = (HEADER_WIDTH + FLIT_DATA_WIDTH - 1) / FLIT_DATA_WIDTH;
    localparam int unsigned FLIT_W       = FLIT_DATA_WIDTH + 3;
    localparam int unsigned HDR_PAD_W    = HEADER_FLITS * FLIT_DATA_WIDTH;
    localparam int unsigned CNT_W        = (HEADER_FLITS > 1) ? $clog2(HEADER_FLITS) : 1;

    localparam logic FT_HEADER  = 1'b0;
    localparam logic FT_PAYLOAD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;

    // Flit layout: {data, tail, head, flit_type}
    function automatic logic [FLIT_W-1:0] pack_flit(
        input logic [FLIT_DATA_WIDTH-1:0] data,
        input logic                       tail,
        input logic                       head,
        input logic                       ftype
    );
        return {data, tail, head, ftype};
    endfunction

    state_e                    state_q, state_d;
    logic                      flit_valid_q, flit_valid_d;
    logic [FLIT_W-1:0]         flit_q, flit_d;
    logic [HEADER_WIDTH-1:0]   header_q, header_d;
    logic                      no_payload_q, no_payload_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      ready_en_q, ready_en_d;

    logic                      out_free;
    logic                      hdr_fire;
    logic                      pay_fire;
    logic [HDR_PAD_W-1:0]      hdr_pad;
    logic [FLIT_DATA_WIDTH-1:0] hdr_chunks [HEADER_FLITS];
    logic [FLIT_DATA_WIDTH-1:0] hdr_chunk;
    logic [FLIT_DATA_WIDTH-1:0] in_chunk0;

    // Stored header split into zero-padded flit-sized chunks
    assign hdr_pad   = HDR_PAD_W'(header_q);
    assign in_chunk0 = FLIT_DATA_WIDTH'(i_header);

    for (genvar g = 0; g < HEADER_FLITS; g++) begin : g_chunk
        assign hdr_chunks[g] = hdr_pad[g*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
    end

    // Output slot can take a new flit when empty or being drained this cycle
    assign out_free = !flit_valid_q || i_flit_ready;

    // ready_en_q keeps both readies low while reset is asserted
    assign o_header_ready  = ready_en_q && (state_q == ST_IDLE)    && out_free;
    assign o_payload_ready = ready_en_q && (state_q == ST_PAYLOAD) && out_free;

    assign hdr_fire = i_header_valid  && o_header_ready;
    assign pay_fire = i_payload_valid && o_payload_ready;

    assign o_flit_valid = flit_valid_q;
    assign o_flit       = flit_q;

    // Header chunk addressed by the chunk counter
    always_comb begin : chunk_sel
        hdr_chunk = '0;
        for (int unsigned k = 0; k < HEADER_FLITS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                hdr_chunk = hdr_chunks[k];
            end
        end
    end

    // Next-state and output-register load logic
    always_comb begin : next_state
        state_d      = state_q;
        header_d     = header_q;
        no_payload_d = no_payload_q;
        cnt_d        = cnt_q;
        flit_d       = flit_q;
        ready_en_d   = 1'b1;
        // Drained slot empties unless reloaded below; a stalled slot holds
        flit_valid_d = out_free ? 1'b0 : flit_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (hdr_fire) begin
                    flit_valid_d = 1'b1;
                    flit_d       = pack_flit(in_chunk0,
                                             (HEADER_FLITS == 1) && i_header_no_payload,
                                             1'b1, FT_HEADER);
                    header_d     = i_header;
                    no_payload_d = i_header_no_payload;
                    cnt_d        = CNT_W'(1);
                    if (HEADER_FLITS > 1) begin
                        state_d = ST_HEADER;
                    end else if (!i_header_no_payload) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_HEADER: begin
                if (out_free) begin
                    flit_valid_d = 1'b1;
                    if (cnt_q == CNT_W'(HEADER_FLITS - 1)) begin
                        flit_d  = pack_flit(hdr_chunk, no_payload_q, 1'b0, FT_HEADER);
                        cnt_d   = '0;
                        state_d = no_payload_q ? ST_IDLE : ST_PAYLOAD;
                    end else begin
                        flit_d  = pack_flit(hdr_chunk, 1'b0, 1'b0, FT_HEADER);
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PAYLOAD: begin
                if (pay_fire) begin
                    flit_valid_d = 1'b1;
                    flit_d       = pack_flit(FLIT_DATA_WIDTH'(i_payload), i_payload_last,
                                             1'b0, FT_PAYLOAD);
                    if (i_payload_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin : regs
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
            header_q     <= '0;
            no_payload_q <= 1'b0;
            cnt_q        <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flit_valid_q <= flit_valid_d;
            flit_q       <= flit_d;
            header_q     <= header_d;
            no_payload_q <= no_payload_d;
            cnt_q        <= cnt_d;
            ready_en_q   <= ready_en_d;
        end
    end

`ifdef TNOC_PACKET_PACKER_STATS_EN
    logic [15:0] packet_count_q, packet_count_d;

    // Count tail flits accepted downstream; wraps naturally at 16 bits
    always_comb begin : stats_next
        packet_count_d = packet_count_q;
        if (flit_valid_q && i_flit_ready && flit_q[2]) begin
            packet_count_d = packet_count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : stats_reg
        if (!i_rst_n) begin
            packet_count_q <= '0;
        end else begin
            packet_count_q <= packet_count_d;
        end
    end

    assign o_packet_count = packet_count_q;
`endif

endmodule
